// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one request outstanding to
// instruction memory, hands fetched words to decode and applies taken-branch redirects.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  decode_ready,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] branch_pc,
  input  logic [DATA_WIDTH-1:0] imm_ext,
  output logic                  fetch_misalign
);

  // state | meaning
  // REQ   | request pc, waiting for memory to accept
  // WAIT  | request accepted, waiting for the response word
  // HOLD  | word presented to decode until consumed
  // DRAIN | one stale response still due, will be discarded
  // HALT  | misaligned redirect seen, idle until reset
  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_req_q, pc_req_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  misalign_q, misalign_d;

  logic [DATA_WIDTH-1:0] target;
  logic                  target_ok;
  logic                  req_fire;

  assign target    = branch_pc + imm_ext;
  assign target_ok = (target[1:0] == 2'b00);
  assign req_fire  = (state_q == S_REQ) && imem_req_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_req_d      = pc_req_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = misalign_q;

    if (redirect && (state_q != S_HALT)) begin
      instr_valid_d = 1'b0;
      if (!target_ok) begin
        misalign_d = 1'b1;
        state_d    = S_HALT;
      end else begin
        pc_d = target;
        // a response arriving alongside the redirect retires the outstanding fetch
        unique case (state_q)
          S_REQ:   state_d = req_fire ? S_DRAIN : S_REQ;
          S_WAIT:  state_d = imem_resp_valid ? S_REQ : S_DRAIN;
          S_HOLD:  state_d = S_REQ;
          S_DRAIN: state_d = imem_resp_valid ? S_REQ : S_DRAIN;
          default: state_d = state_q;
        endcase
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            pc_req_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            instr_d       = imem_resp_data;
            instr_pc_d    = pc_req_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + PC_STEP;
            state_d       = S_HOLD;
          end
        end
        S_HOLD: begin
          if (decode_ready) begin
            instr_valid_d = 1'b0;
            state_d       = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_resp_valid) state_d = S_REQ;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      pc_req_q      <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_req_q      <= pc_req_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  // gated by rst so nothing is offered to memory while reset is held
  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_addr      = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences, a redirect-target vector table and a
// randomized run against a transaction-level model of the fetched address stream.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_ready = 1'b0, resp_valid = 1'b0, decode_ready = 1'b0, redirect = 1'b0;
  logic [31:0] resp_data = '0, branch_pc = '0, imm_ext = '0;

  logic        req_valid_a, instr_valid_a, mis_a;
  logic [31:0] addr_a, instr_a, instr_pc_a;
  logic        req_valid_b, instr_valid_b, mis_b;
  logic [31:0] addr_b, instr_b, instr_pc_b;

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid_a), .imem_req_ready(req_ready), .imem_addr(addr_a),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .instr_valid(instr_valid_a), .instr(instr_a), .instr_pc(instr_pc_a),
    .decode_ready(decode_ready), .redirect(redirect),
    .branch_pc(branch_pc), .imm_ext(imm_ext), .fetch_misalign(mis_a)
  );

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid_b), .imem_req_ready(req_ready), .imem_addr(addr_b),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .instr_valid(instr_valid_b), .instr(instr_b), .instr_pc(instr_pc_b),
    .decode_ready(decode_ready), .redirect(redirect),
    .branch_pc(branch_pc), .imm_ext(imm_ext), .fetch_misalign(mis_b)
  );

  // helper tasks observe whichever instance use_b selects
  logic        use_b = 1'b0;
  logic        obs_req_valid, obs_instr_valid, obs_mis;
  logic [31:0] obs_addr, obs_instr, obs_instr_pc;
  assign obs_req_valid   = use_b ? req_valid_b   : req_valid_a;
  assign obs_instr_valid = use_b ? instr_valid_b : instr_valid_a;
  assign obs_mis         = use_b ? mis_b         : mis_a;
  assign obs_addr        = use_b ? addr_b        : addr_a;
  assign obs_instr       = use_b ? instr_b       : instr_a;
  assign obs_instr_pc    = use_b ? instr_pc_b    : instr_pc_a;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] bpc;
    logic [31:0] imm;
    logic [31:0] addr;
    logic        mis;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; decode_ready = 1'b0; redirect = 1'b0;
    tick;
    tick;
    chk("rst.req_valid", obs_req_valid, 0);
    chk("rst.instr_valid", obs_instr_valid, 0);
    chk("rst.instr", obs_instr, 0);
    chk("rst.instr_pc", obs_instr_pc, 0);
    chk("rst.misalign", obs_mis, 0);
    rst = 1'b0;
    #1;
  endtask

  // drive one zero-wait fetch from REQ through to HOLD
  task automatic fetch_one(input logic [31:0] exp_addr, input string tag);
    int n = 0;
    req_ready = 1'b1;
    while (!obs_req_valid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, ".req"}, obs_req_valid, 1);
    chk({tag, ".addr"}, obs_addr, exp_addr);
    tick;
    req_ready = 1'b0;
    chk({tag, ".wait_noreq"}, obs_req_valid, 0);
    resp_valid = 1'b1;
    resp_data  = mem_word(exp_addr);
    tick;
    resp_valid = 1'b0;
    chk({tag, ".valid"}, obs_instr_valid, 1);
    chk({tag, ".pc"}, obs_instr_pc, exp_addr);
    chk({tag, ".instr"}, obs_instr, mem_word(exp_addr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    int          pending;
    int          delay;
    int          hs;
    int          off;

    vecs[0] = '{32'h0000_0008, 32'hFFFF_FFF8, 32'h0000_0000, 1'b0};
    vecs[1] = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0};
    vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0004, 1'b0};
    vecs[3] = '{32'h0000_0100, 32'hFFFF_F000, 32'hFFFF_F100, 1'b0};
    vecs[4] = '{32'h0000_0007, 32'h0000_0001, 32'h0000_0008, 1'b0};
    vecs[5] = '{32'h0000_0004, 32'h0000_0002, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1};

    // zero-wait memory, decode always ready: three cycles per instruction
    do_reset;
    req_ready = 1'b1;
    decode_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("t1.req_valid", obs_req_valid, (k % 3 == 0) ? 1 : 0);
      if (k % 3 == 0) chk("t1.addr", obs_addr, 32'(4 * (k / 3)));
      chk("t1.instr_valid", obs_instr_valid, (k % 3 == 2) ? 1 : 0);
      if (k % 3 == 2) begin
        chk("t1.instr_pc", obs_instr_pc, 32'(4 * (k / 3)));
        chk("t1.instr", obs_instr, mem_word(32'(4 * (k / 3))));
      end
      resp_valid = (k % 3 == 1);
      resp_data  = mem_word(32'(4 * (k / 3)));
      tick;
    end
    resp_valid = 1'b0; req_ready = 1'b0; decode_ready = 1'b0;

    // decode stalls five cycles in HOLD
    fetch_one(32'hC, "t2");
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t2.hold_valid", obs_instr_valid, 1);
      chk("t2.hold_pc", obs_instr_pc, 32'hC);
      chk("t2.hold_instr", obs_instr, mem_word(32'hC));
      chk("t2.hold_noreq", obs_req_valid, 0);
    end
    decode_ready = 1'b1;
    tick;
    decode_ready = 1'b0;
    chk("t2.released", obs_instr_valid, 0);
    chk("t2.next_req", obs_req_valid, 1);
    chk("t2.next_addr", obs_addr, 32'h10);

    // redirect while waiting: stale response dropped
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    redirect = 1'b1; branch_pc = 32'h8; imm_ext = 32'hFFFF_FFF8;
    tick;
    redirect = 1'b0;
    chk("t3.drain_noreq", obs_req_valid, 0);
    resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF;
    tick;
    resp_valid = 1'b0;
    chk("t3.dropped", obs_instr_valid, 0);
    chk("t3.req", obs_req_valid, 1);
    chk("t3.addr", obs_addr, 32'h0);
    fetch_one(32'h0, "t3");

    // redirect and decode_ready together in HOLD
    redirect = 1'b1; decode_ready = 1'b1; branch_pc = 32'h10; imm_ext = 32'h20;
    tick;
    redirect = 1'b0; decode_ready = 1'b0;
    chk("t4.valid_cleared", obs_instr_valid, 0);
    chk("t4.req", obs_req_valid, 1);
    chk("t4.addr", obs_addr, 32'h30);
    fetch_one(32'h30, "t4");

    // misaligned redirect halts fetch until reset
    decode_ready = 1'b1;
    tick;
    decode_ready = 1'b0;
    redirect = 1'b1; branch_pc = 32'h4; imm_ext = 32'h2;
    tick;
    redirect = 1'b0;
    chk("t5.misalign", obs_mis, 1);
    chk("t5.noreq", obs_req_valid, 0);
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = 32'h1234_5678; decode_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t5.halt_noreq", obs_req_valid, 0);
      chk("t5.halt_novalid", obs_instr_valid, 0);
      chk("t5.sticky", obs_mis, 1);
    end
    do_reset;
    chk("t5.restart_req", obs_req_valid, 1);

    // redirect target arithmetic and alignment, from REQ with memory not ready
    foreach (vecs[i]) begin
      do_reset;
      redirect = 1'b1; branch_pc = vecs[i].bpc; imm_ext = vecs[i].imm;
      tick;
      redirect = 1'b0;
      chk("tbl.addr", obs_addr, vecs[i].addr);
      chk("tbl.misalign", obs_mis, vecs[i].mis);
      chk("tbl.req_valid", obs_req_valid, vecs[i].mis ? 0 : 1);
    end

    // top-of-space reset PC wraps; reset mid-WAIT discards the late response
    use_b = 1'b1;
    do_reset;
    fetch_one(32'hFFFF_FFFC, "t6a");
    decode_ready = 1'b1;
    tick;
    decode_ready = 1'b0;
    fetch_one(32'h0, "t6b");
    decode_ready = 1'b1;
    tick;
    decode_ready = 1'b0;
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    resp_valid = 1'b1; resp_data = 32'hBAD0_BAD0;
    tick;
    resp_valid = 1'b0;
    chk("t6.late_resp_ignored", obs_instr_valid, 0);
    chk("t6.restart_req", obs_req_valid, 1);
    chk("t6.restart_addr", obs_addr, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, "t6c");
    use_b = 1'b0;

    // randomized run: model tracks the address decode must see next
    do_reset;
    exp_pc = 32'h0; pending = 0; delay = 0; pend_addr = '0; hs = 0;
    for (int c = 0; c < 3000; c++) begin
      if (instr_valid_a) begin
        chk("rnd.pc", instr_pc_a, exp_pc);
        chk("rnd.instr", instr_a, mem_word(exp_pc));
      end
      if (req_valid_a) chk("rnd.one_outstanding", 32'(pending), 0);

      req_ready    = ($urandom_range(0, 1) == 1);
      decode_ready = ($urandom_range(0, 3) != 0);
      resp_valid   = (pending != 0) && (delay == 0);
      resp_data    = mem_word(pend_addr);
      redirect     = ($urandom_range(0, 9) == 0);
      branch_pc    = 32'($urandom_range(0, 4095)) << 2;
      off          = int'($urandom_range(0, 255)) - 128;
      imm_ext      = 32'(off * 4);

      if (req_valid_a && req_ready && !redirect) chk("rnd.addr", addr_a, exp_pc);

      if (resp_valid) pending = 0;
      else if (pending != 0) delay--;
      if (req_valid_a && req_ready) begin
        pending   = 1;
        pend_addr = addr_a;
        delay     = $urandom_range(0, 2);
      end

      if (redirect) exp_pc = branch_pc + imm_ext;
      else if (instr_valid_a && decode_ready) begin
        exp_pc = exp_pc + 32'h4;
        hs++;
      end
      tick;
    end
    redirect = 1'b0; resp_valid = 1'b0; req_ready = 1'b0;
    chk("rnd.progress", (hs >= 50) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
